// File: rtl/overlay_window_ctrl.sv
// Pixel-position sequencer for the video overlay stage: tracks (x,y), decodes the MOG
// window and box outline per pixel, and applies shadowed configuration only at sof.
module overlay_window_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW       = 11,
  parameter int BORDER   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic          sof,
  input  logic          eol,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [3:0]    cfg_output_source,
  input  logic          cfg_mog_en,
  input  logic [CW-1:0] cfg_mog_x0,
  input  logic [CW-1:0] cfg_mog_x1,
  input  logic [CW-1:0] cfg_mog_y0,
  input  logic [CW-1:0] cfg_mog_y1,
  input  logic          cfg_box_en,
  input  logic [CW-1:0] cfg_box_x0,
  input  logic [CW-1:0] cfg_box_x1,
  input  logic [CW-1:0] cfg_box_y0,
  input  logic [CW-1:0] cfg_box_y1,
  output logic [3:0]    output_source,
  output logic          mog_window_enable,
  output logic          video_overlay_window_enable,
  output logic          vovrlay_is_fg,
  output logic          frame_done,
  output logic          line_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_VBLANK = 2'd2
  } state_t;

  typedef struct packed {
    logic          en;
    logic [CW-1:0] x0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y0;
    logic [CW-1:0] y1;
  } win_t;

  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAST_X   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] LAST_Y   = CW'(V_ACTIVE - 1);
  localparam logic [CW:0]   BORDER_W = (CW+1)'(BORDER);
  localparam win_t          WIN_ZERO = win_t'({(4*CW+1){1'b0}});

  // Inclusive rectangle hit; one extra bit keeps every comparison free of wrap.
  function automatic logic in_win(input win_t w, input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [CW:0] xe;
    logic [CW:0] ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    return w.en && ({1'b0, w.x0} <= xe) && (xe <= {1'b0, w.x1}) &&
           ({1'b0, w.y0} <= ye) && (ye <= {1'b0, w.y1});
  endfunction

  function automatic logic on_outline(input win_t w, input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [CW:0] xe;
    logic [CW:0] ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    return (xe < ({1'b0, w.x0} + BORDER_W)) || ((xe + BORDER_W) > {1'b0, w.x1}) ||
           (ye < ({1'b0, w.y0} + BORDER_W)) || ((ye + BORDER_W) > {1'b0, w.y1});
  endfunction

  state_t        state_r;
  logic [CW-1:0] x_r;
  logic [CW-1:0] y_r;
  logic          pend_r;
  logic [3:0]    pend_src_r;
  win_t          pend_mog_r;
  win_t          pend_box_r;
  logic [3:0]    act_src_r;
  win_t          act_mog_r;
  win_t          act_box_r;
  logic          mog_r;
  logic          vov_r;
  logic          fg_r;
  logic          fd_r;
  logic          err_r;

  state_t        state_n_s;
  logic [CW-1:0] x_n_s;
  logic [CW-1:0] y_n_s;
  logic          fd_n_s;
  logic          err_set_s;
  logic          pix_sof_s;
  logic          xfer_s;
  logic          in_frame_s;
  logic [CW-1:0] cur_x_s;
  logic [CW-1:0] cur_y_s;
  win_t          cur_mog_s;
  win_t          cur_box_s;
  win_t          cfg_mog_s;
  win_t          cfg_box_s;
  logic          mog_hit_s;
  logic          box_hit_s;
  logic          fg_hit_s;

  assign cfg_mog_s = {cfg_mog_en, cfg_mog_x0, cfg_mog_x1, cfg_mog_y0, cfg_mog_y1};
  assign cfg_box_s = {cfg_box_en, cfg_box_x0, cfg_box_x1, cfg_box_y0, cfg_box_y1};

  // Current pixel view: sof forces (0,0) and sees the config it is about to load.
  always_comb begin
    pix_sof_s  = pix_valid && sof;
    xfer_s     = cfg_valid && !pend_r;
    in_frame_s = pix_valid && (pix_sof_s || (state_r == ST_ACTIVE));
    if (pix_sof_s) begin
      cur_x_s = ZERO_C;
      cur_y_s = ZERO_C;
    end else begin
      cur_x_s = x_r;
      cur_y_s = y_r;
    end
    if (pix_sof_s && pend_r) begin
      cur_mog_s = pend_mog_r;
      cur_box_s = pend_box_r;
    end else begin
      cur_mog_s = act_mog_r;
      cur_box_s = act_box_r;
    end
    mog_hit_s = in_frame_s && in_win(cur_mog_s, cur_x_s, cur_y_s);
    box_hit_s = in_frame_s && in_win(cur_box_s, cur_x_s, cur_y_s);
    fg_hit_s  = box_hit_s && on_outline(cur_box_s, cur_x_s, cur_y_s);
  end

  // Next-state and position counter logic.
  always_comb begin
    state_n_s = state_r;
    x_n_s     = x_r;
    y_n_s     = y_r;
    fd_n_s    = 1'b0;
    err_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pix_sof_s) begin
          state_n_s = ST_ACTIVE;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        state_n_s = ST_ACTIVE;
        if (pix_sof_s && ((x_r != ZERO_C) || (y_r != ZERO_C))) begin
          err_set_s = 1'b1;
        end else begin
          err_set_s = 1'b0;
        end
      end
      ST_VBLANK: begin
        if (pix_sof_s) begin
          state_n_s = ST_ACTIVE;
        end else begin
          state_n_s = ST_VBLANK;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
    if (in_frame_s) begin
      if (eol) begin
        x_n_s = ZERO_C;
        if (cur_y_s == LAST_Y) begin
          y_n_s     = ZERO_C;
          fd_n_s    = 1'b1;
          state_n_s = ST_VBLANK;
        end else begin
          y_n_s = cur_y_s + ONE_C;
        end
      end else if (cur_x_s == LAST_X) begin
        // missing eol: pin x at the last column and flag the line
        x_n_s     = LAST_X;
        y_n_s     = cur_y_s;
        err_set_s = 1'b1;
      end else begin
        x_n_s = cur_x_s + ONE_C;
        y_n_s = cur_y_s;
      end
    end else begin
      x_n_s = x_r;
      y_n_s = y_r;
    end
  end

  // State, counters, config shadow and registered per-pixel outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      x_r        <= ZERO_C;
      y_r        <= ZERO_C;
      pend_r     <= 1'b0;
      pend_src_r <= 4'd0;
      pend_mog_r <= WIN_ZERO;
      pend_box_r <= WIN_ZERO;
      act_src_r  <= 4'd0;
      act_mog_r  <= WIN_ZERO;
      act_box_r  <= WIN_ZERO;
      mog_r      <= 1'b0;
      vov_r      <= 1'b0;
      fg_r       <= 1'b0;
      fd_r       <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_n_s;
      x_r     <= x_n_s;
      y_r     <= y_n_s;
      fd_r    <= fd_n_s;
      err_r   <= err_r | err_set_s;
      // a transfer coinciding with sof lands in the shadow and waits for the next frame
      if (xfer_s) begin
        pend_r     <= 1'b1;
        pend_src_r <= cfg_output_source;
        pend_mog_r <= cfg_mog_s;
        pend_box_r <= cfg_box_s;
      end else if (pix_sof_s) begin
        pend_r <= 1'b0;
      end
      if (pix_sof_s && pend_r) begin
        act_src_r <= pend_src_r;
        act_mog_r <= pend_mog_r;
        act_box_r <= pend_box_r;
      end
      if (pix_valid) begin
        mog_r <= mog_hit_s;
        vov_r <= box_hit_s;
        fg_r  <= fg_hit_s;
      end
    end
  end

  assign cfg_ready                   = ~pend_r;
  assign output_source               = act_src_r;
  assign mog_window_enable           = mog_r;
  assign video_overlay_window_enable = vov_r;
  assign vovrlay_is_fg               = fg_r;
  assign frame_done                  = fd_r;
  assign line_err                    = err_r;

endmodule

// File: tb/tb_overlay_window_ctrl.sv
// Directed bench for overlay_window_ctrl on a reduced 112x60 raster: expected per-pixel
// outputs come from a reference decode of the configuration the bench itself wrote.
module tb_overlay_window_ctrl;

  localparam int H  = 112;
  localparam int V  = 60;
  localparam int CW = 11;
  localparam int B  = 2;

  typedef struct {
    int src;
    bit mog_en;
    int mx0, mx1, my0, my1;
    bit box_en;
    int bx0, bx1, by0, by1;
  } cfg_s;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_valid = 1'b0;
  logic sof = 1'b0;
  logic eol = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [3:0] cfg_output_source;
  logic cfg_mog_en, cfg_box_en;
  logic [CW-1:0] cfg_mog_x0, cfg_mog_x1, cfg_mog_y0, cfg_mog_y1;
  logic [CW-1:0] cfg_box_x0, cfg_box_x1, cfg_box_y0, cfg_box_y1;
  logic [3:0] output_source;
  logic mog_window_enable, video_overlay_window_enable, vovrlay_is_fg, frame_done, line_err;

  cfg_s offer_cfg, m_act, m_pend, c1, c2, c3, cz;
  bit   offer, m_pend_v, m_inframe, m_err;
  logic [8:0] exp_q[$];
  logic [8:0] last_exp;
  logic [8:0] obs;
  int total = 0;
  int bad = 0;
  int c_mog, c_vov, c_fg, c_fd;

  overlay_window_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CW(CW), .BORDER(B)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .sof(sof), .eol(eol),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_output_source(cfg_output_source),
    .cfg_mog_en(cfg_mog_en), .cfg_mog_x0(cfg_mog_x0), .cfg_mog_x1(cfg_mog_x1),
    .cfg_mog_y0(cfg_mog_y0), .cfg_mog_y1(cfg_mog_y1),
    .cfg_box_en(cfg_box_en), .cfg_box_x0(cfg_box_x0), .cfg_box_x1(cfg_box_x1),
    .cfg_box_y0(cfg_box_y0), .cfg_box_y1(cfg_box_y1),
    .output_source(output_source), .mog_window_enable(mog_window_enable),
    .video_overlay_window_enable(video_overlay_window_enable),
    .vovrlay_is_fg(vovrlay_is_fg), .frame_done(frame_done), .line_err(line_err)
  );

  always #5 clk = ~clk;

  assign cfg_output_source = offer_cfg.src[3:0];
  assign cfg_mog_en = offer_cfg.mog_en;
  assign cfg_mog_x0 = offer_cfg.mx0[CW-1:0];
  assign cfg_mog_x1 = offer_cfg.mx1[CW-1:0];
  assign cfg_mog_y0 = offer_cfg.my0[CW-1:0];
  assign cfg_mog_y1 = offer_cfg.my1[CW-1:0];
  assign cfg_box_en = offer_cfg.box_en;
  assign cfg_box_x0 = offer_cfg.bx0[CW-1:0];
  assign cfg_box_x1 = offer_cfg.bx1[CW-1:0];
  assign cfg_box_y0 = offer_cfg.by0[CW-1:0];
  assign cfg_box_y1 = offer_cfg.by1[CW-1:0];
  assign obs = {output_source, mog_window_enable, video_overlay_window_enable,
                vovrlay_is_fg, frame_done, line_err};

  function automatic bit inr(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Reference decode, packed as {src, mog, box, fg, frame_done, line_err}.
  function automatic logic [8:0] expect_px(cfg_s c, int x, int y, bit inf, bit fd, bit err);
    bit mog, inb, fg;
    logic [3:0] s;
    mog = inf && c.mog_en && inr(x, c.mx0, c.mx1) && inr(y, c.my0, c.my1);
    inb = inf && c.box_en && inr(x, c.bx0, c.bx1) && inr(y, c.by0, c.by1);
    fg  = inb && ((x < c.bx0 + B) || (x + B > c.bx1) || (y < c.by0 + B) || (y + B > c.by1));
    s   = c.src[3:0];
    return {s, mog, inb, fg, fd, err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One pixel: drive, model, push expectation; one edge later pop and compare.
  task automatic px(input int x, input int y, input bit s, input bit e, input bit ev_err);
    bit xfer, inf, fd;
    logic [8:0] ev, got;
    pix_valid = 1'b1; sof = s; eol = e; cfg_valid = offer;
    #1;
    chk($sformatf("cfg_ready(%0d,%0d)", x, y), {31'd0, cfg_ready}, {31'd0, !m_pend_v});
    xfer = offer && !m_pend_v;
    if (s) begin
      m_inframe = 1'b1;
      if (m_pend_v) begin
        m_act = m_pend;
        m_pend_v = 1'b0;
      end
    end
    inf = m_inframe;
    fd  = inf && e && (y == V - 1);
    if (ev_err) m_err = 1'b1;
    exp_q.push_back(expect_px(m_act, x, y, inf, fd, m_err));
    if (fd) m_inframe = 1'b0;
    if (xfer) begin
      m_pend = offer_cfg;
      m_pend_v = 1'b1;
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0; sof = 1'b0; eol = 1'b0; cfg_valid = 1'b0; offer = 1'b0;
    got = obs;
    ev = exp_q.pop_front();
    last_exp = ev;
    last_exp[1] = 1'b0;
    chk($sformatf("pix(%0d,%0d)", x, y), {23'd0, got}, {23'd0, ev});
    c_mog += int'(got[4]);
    c_vov += int'(got[3]);
    c_fg  += int'(got[2]);
    c_fd  += int'(got[1]);
  endtask

  task automatic idle_chk();
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("hold", {23'd0, obs}, {23'd0, last_exp});
  endtask

  task automatic reset_chk();
    rst = 1'b0; pix_valid = 1'b0; sof = 1'b0; eol = 1'b0; cfg_valid = 1'b0; offer = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_act = cz; m_pend_v = 1'b0; m_inframe = 1'b0; m_err = 1'b0;
    last_exp = 9'd0;
    chk("reset", {22'd0, obs, cfg_ready}, {22'd0, 9'd0, 1'b1});
  endtask

  task automatic frame(input int offer_at, input cfg_s c, input int hold_at,
                       input int wm, input int wv, input int wf);
    c_mog = 0; c_vov = 0; c_fg = 0; c_fd = 0;
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        if (yy * H + xx == offer_at) begin
          offer = 1'b1;
          offer_cfg = c;
        end
        px(xx, yy, (xx == 0) && (yy == 0), xx == H - 1, 1'b0);
        if (yy * H + xx == hold_at) idle_chk();
      end
    end
    chk("mog_count", wm, c_mog);
    chk("box_count", wv, c_vov);
    chk("fg_count", wf, c_fg);
    chk("frame_done_count", 1, c_fd);
  endtask

  initial begin
    cz = '{default: 0};
    offer_cfg = cz; m_act = cz; m_pend = cz;
    offer = 1'b0; m_pend_v = 1'b0; m_inframe = 1'b0; m_err = 1'b0;
    c1 = '{src: 3, mog_en: 1, mx0: 10, mx1: 19, my0: 10, my1: 19,
           box_en: 1, bx0: 100, bx1: 109, by0: 50, by1: 59};
    c2 = '{src: 5, mog_en: 0, mx0: 0, mx1: 0, my0: 0, my1: 0,
           box_en: 1, bx0: 700, bx1: 10, by0: 0, by1: 59};
    c3 = '{src: 9, mog_en: 1, mx0: 0, mx1: H - 1, my0: 0, my1: V - 1,
           box_en: 0, bx0: 0, bx1: 0, by0: 0, by1: 0};

    reset_chk();
    for (int i = 0; i < 3; i++) px(i, 0, 1'b0, 1'b0, 1'b0);

    // config written mid-frame: this frame keeps the cleared config
    frame(5 * H + 5, c1, -1, 0, 0, 0);
    for (int i = 0; i < 5; i++) px(i, 0, 1'b0, i == 4, 1'b0);

    // new config live; hold check on the box interior pixel (104,54)
    frame(-1, cz, 54 * H + 104, 100, 100, 64);

    // transfer on the sof cycle itself: this frame still uses c1
    frame(0, c2, -1, 100, 100, 64);

    // c2 now active (empty box); overrun a line by 60 pixels
    for (int i = 0; i < H + 60; i++) begin
      px((i < H) ? i : H - 1, 0, i == 0, i == H + 59, (i >= H - 1) && (i != H + 59));
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        offer = 1'b1;
        offer_cfg = c3;
      end
      px(i, 1, 1'b0, 1'b0, 1'b0);
    end

    // reset drops the pending c3; next frame runs on the cleared config
    reset_chk();
    for (int i = 0; i < 4; i++) px(i, 0, 1'b0, 1'b0, 1'b0);
    for (int yy = 0; yy < 3; yy++) begin
      for (int xx = 0; xx < H; xx++) px(xx, yy, (xx == 0) && (yy == 0), xx == H - 1, 1'b0);
    end
    for (int xx = 0; xx < 5; xx++) px(xx, 3, 1'b0, 1'b0, 1'b0);
    px(0, 0, 1'b1, 1'b0, 1'b1);
    for (int xx = 1; xx < 4; xx++) px(xx, 0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
